// File: rtl/riscv_instr_mem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Response entries and the fetch address check are defined here.
package riscv_instr_mem_pkg;

    localparam int MAX_LATENCY = 8;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1C00_0000;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } instr_resp_t;

    // 33-bit arithmetic so a borrow or wrap past 32'hFFFF_FFFF lands out of range.
    function automatic logic fetch_err(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned mem_words
    );
        logic [32:0] off;
        logic [32:0] limit;
        off   = {1'b0, addr} - {1'b0, base};
        limit = 33'(mem_words) << 2;
        return off[32] | (off >= limit) | (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/riscv_instr_resp_delay.sv
// Fixed-latency response pipeline: {valid, err} enters at grant, SRAM data
// joins at stage 1 and the entry leaves at stage LATENCY.
module riscv_instr_resp_delay
    import riscv_instr_mem_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vld_p0,
    input  logic        err_p0,
    input  logic [31:0] mem_rdata_i,
    output instr_resp_t resp_o
);

    logic        vld_p [1:LATENCY];
    logic        err_p [1:LATENCY];
    logic [31:0] data_p1;

    // Stage 0 -> 1: grant cycle captured; later stages shift with no stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= LATENCY; k++) begin
                vld_p[k] <= 1'b0;
            end
        end else begin
            vld_p[1] <= vld_p0;
            for (int k = 2; k <= LATENCY; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        err_p[1] <= err_p0;
        for (int k = 2; k <= LATENCY; k++) begin
            err_p[k] <= err_p[k-1];
        end
    end

    assign data_p1 = err_p[1] ? 32'h0 : mem_rdata_i;

    generate
        if (LATENCY == 1) begin : g_direct
            assign resp_o = vld_p[1] ? {1'b1, err_p[1], data_p1} : '0;
        end else begin : g_registered
            logic [31:0] data_p [2:LATENCY];

            // Stage 1 -> 2: SRAM word registered, then delayed to the output stage
            always_ff @(posedge clk) begin
                data_p[2] <= data_p1;
                for (int k = 3; k <= LATENCY; k++) begin
                    data_p[k] <= data_p[k-1];
                end
            end

            assign resp_o = vld_p[LATENCY] ? {1'b1, err_p[LATENCY], data_p[LATENCY]} : '0;
        end
    endgenerate

endmodule

// File: rtl/riscv_instr_mem_responder.sv
// Slave side of the instruction fetch interface: grants, reads a synchronous
// SRAM and returns in-order responses after a fixed latency.
module riscv_instr_mem_responder
    import riscv_instr_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS       = 4096,
    parameter logic [31:0] BASE_ADDR       = DEFAULT_BASE_ADDR,
    parameter int          LATENCY         = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         instr_req_i,
    input  logic [31:0]                  instr_addr_i,
    output logic                         instr_gnt_o,
    output logic                         instr_rvalid_o,
    output logic [31:0]                  instr_rdata_o,
    output logic                         instr_err_o,
    input  logic                         stall_i,
    output logic                         mem_req_o,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
    input  logic [31:0]                  mem_rdata_i
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [CW-1:0] outstanding;
    logic          gnt;
    logic          acc_err;
    logic [AW-1:0] word_idx;
    instr_resp_t   resp;

    assign acc_err  = fetch_err(instr_addr_i, BASE_ADDR, MEM_WORDS);
    assign word_idx = AW'(instr_addr_i[31:2] - BASE_ADDR[31:2]);

    // A response leaving this cycle frees its slot for a same-cycle grant.
    assign gnt = instr_req_i & ~stall_i & ~rst &
                 ((outstanding < CW'(MAX_OUTSTANDING)) | resp.valid);

    assign instr_gnt_o = gnt;
    assign mem_req_o   = gnt & ~acc_err;
    assign mem_addr_o  = mem_req_o ? word_idx : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({gnt, resp.valid})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    riscv_instr_resp_delay #(
        .LATENCY (LATENCY)
    ) u_resp_delay (
        .clk         (clk),
        .rst         (rst),
        .vld_p0      (gnt),
        .err_p0      (acc_err),
        .mem_rdata_i (mem_rdata_i),
        .resp_o      (resp)
    );

    assign instr_rvalid_o = resp.valid;
    assign instr_rdata_o  = resp.data;
    assign instr_err_o    = resp.err;

    a_outstanding_cap : assert property (@(posedge clk) disable iff (rst)
        outstanding <= CW'(MAX_OUTSTANDING));
    a_no_orphan_rvalid : assert property (@(posedge clk) disable iff (rst)
        !(resp.valid && outstanding == '0));

endmodule

// File: tb/tb_riscv_instr_mem_responder.sv
// Two responders (LATENCY 2 / MAX_OUTSTANDING 2 and LATENCY 3 / MAX_OUTSTANDING 1)
// driven by fetch requesters and checked against a grant/response queue model.
module tb_riscv_instr_mem_responder;

    localparam logic [31:0] BASE  = 32'h1C00_0000;
    localparam int          WORDS = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        req   [2];
    logic [31:0] addr  [2];
    logic        gnt   [2];
    logic        rv    [2];
    logic [31:0] rd    [2];
    logic        er    [2];
    logic        mreq  [2];
    logic [11:0] maddr [2];
    logic [31:0] mrd   [2];

    logic [31:0] mem [0:WORDS-1];

    always #5 clk = ~clk;

    riscv_instr_mem_responder #(
        .MEM_WORDS(WORDS), .BASE_ADDR(BASE), .LATENCY(2), .MAX_OUTSTANDING(2)
    ) dut0 (
        .clk(clk), .rst(rst), .instr_req_i(req[0]), .instr_addr_i(addr[0]),
        .instr_gnt_o(gnt[0]), .instr_rvalid_o(rv[0]), .instr_rdata_o(rd[0]),
        .instr_err_o(er[0]), .stall_i(stall), .mem_req_o(mreq[0]),
        .mem_addr_o(maddr[0]), .mem_rdata_i(mrd[0])
    );

    riscv_instr_mem_responder #(
        .MEM_WORDS(WORDS), .BASE_ADDR(BASE), .LATENCY(3), .MAX_OUTSTANDING(1)
    ) dut1 (
        .clk(clk), .rst(rst), .instr_req_i(req[1]), .instr_addr_i(addr[1]),
        .instr_gnt_o(gnt[1]), .instr_rvalid_o(rv[1]), .instr_rdata_o(rd[1]),
        .instr_err_o(er[1]), .stall_i(stall), .mem_req_o(mreq[1]),
        .mem_addr_o(maddr[1]), .mem_rdata_i(mrd[1])
    );

    // Synchronous SRAM: one-cycle read latency, garbage when not read
    always @(posedge clk) begin
        if (mreq[0]) mrd[0] <= mem[maddr[0]];
        else         mrd[0] <= $urandom;
    end
    always @(posedge clk) begin
        if (mreq[1]) mrd[1] <= mem[maddr[1]];
        else         mrd[1] <= $urandom;
    end

    typedef struct {
        int          inst;
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        pend[$];
    int          outs [2];
    int          lat  [2];
    int          mo   [2];
    bit          pv   [2];
    logic [31:0] pa   [2];
    logic [31:0] script [2][0:31];
    int          sp   [2];
    int          slen [2];
    bit          rnd;
    int          cyc;
    int          n_chk;
    int          n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic add_both(input logic [31:0] a);
        for (int i = 0; i < 2; i++) begin
            script[i][slen[i]] = a;
            slen[i]++;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned k;
        k = $urandom % 10;
        if (k < 6)       return BASE + 32'(4 * ($urandom % WORDS));
        else if (k == 6) return BASE - 32'(4 * (1 + $urandom % 4));
        else if (k == 7) return BASE + 32'h4000 + 32'(4 * ($urandom % 4));
        else if (k == 8) return BASE + 32'(4 * ($urandom % WORDS)) + 32'(1 + $urandom % 3);
        else begin
            k = $urandom % 3;
            if (k == 0)      return 32'hFFFF_FFFC;
            else if (k == 1) return BASE + 32'h3FFC;
            else             return BASE;
        end
    endfunction

    // Reference: grants are allowed while fewer than MAX_OUTSTANDING responses
    // are still owed (after the one due this cycle); each grant owes exactly
    // one response LATENCY cycles later.
    task automatic check_inst(input int i);
        bit          exp_rv, exp_er, exp_g, exp_mr, e;
        logic [31:0] exp_rd, exp_ma, data;
        longint      off;
        int          idx;
        string       p;
        exp_rv = 0; exp_er = 0; exp_rd = 0; exp_mr = 0; exp_ma = 0; idx = -1;
        p = $sformatf("i%0d c%0d", i, cyc);
        if (rst) begin
            for (int k = pend.size() - 1; k >= 0; k--)
                if (pend[k].inst == i) pend.delete(k);
            outs[i] = 0;
        end else begin
            for (int k = 0; k < pend.size(); k++)
                if (pend[k].inst == i) begin idx = k; break; end
            if (idx >= 0 && pend[idx].due == cyc) begin
                exp_rv = 1;
                exp_er = pend[idx].err;
                exp_rd = pend[idx].data;
                pend.delete(idx);
                outs[i]--;
            end
        end
        exp_g = !rst && pv[i] && !stall && (outs[i] < mo[i]);
        chk({p, " gnt"},    32'(gnt[i]), 32'(exp_g));
        chk({p, " rvalid"}, 32'(rv[i]),  32'(exp_rv));
        chk({p, " rdata"},  rd[i],       exp_rd);
        chk({p, " err"},    32'(er[i]),  32'(exp_er));
        if (exp_g) begin
            off = longint'(pa[i]) - longint'(BASE);
            e = (off < 0) || (off >= 4 * WORDS) || (pa[i][1:0] != 2'b00);
            data = 32'h0;
            if (!e) begin
                exp_mr = 1;
                exp_ma = 32'(off / 4);
                data   = mem[off / 4];
            end
            pend.push_back('{inst: i, due: cyc + lat[i], err: e, data: data});
            outs[i]++;
            pv[i] = 0;
        end
        chk({p, " mem_req"},  32'(mreq[i]),  32'(exp_mr));
        chk({p, " mem_addr"}, 32'(maddr[i]), exp_ma);
    endtask

    task automatic cycle();
        if (rnd) begin
            stall = ($urandom % 5 == 0);
            rst   = ($urandom % 300 == 0);
        end
        for (int i = 0; i < 2; i++) begin
            if (!pv[i]) begin
                if (sp[i] < slen[i]) begin
                    pv[i] = 1;
                    pa[i] = script[i][sp[i]];
                    sp[i]++;
                end else if (rnd && ($urandom % 3 != 0)) begin
                    pv[i] = 1;
                    pa[i] = rand_addr();
                end
            end
            req[i]  = pv[i];
            addr[i] = pa[i];
        end
        @(negedge clk);
        check_inst(0);
        check_inst(1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        n_chk = 0; n_err = 0; cyc = 0; rnd = 0;
        lat[0] = 2; lat[1] = 3; mo[0] = 2; mo[1] = 1;
        for (int i = 0; i < 2; i++) begin
            outs[i] = 0; pv[i] = 0; pa[i] = BASE; sp[i] = 0; slen[i] = 0;
            req[i] = 0; addr[i] = BASE;
        end
        for (int w = 0; w < WORDS; w++) mem[w] = $urandom;
        mem[0] = 32'h0000_0013;
        rst = 1; stall = 0;
        @(posedge clk);
        #1;

        // Reset state, with a request already waiting
        add_both(BASE);
        repeat (2) cycle();
        rst = 0;
        repeat (6) cycle();

        // Back-to-back fetches: full throughput vs capped at one outstanding
        add_both(BASE); add_both(BASE + 4); add_both(BASE + 8);
        repeat (14) cycle();

        // Below base, past the end, misaligned
        add_both(32'h1BFF_FFFC); add_both(32'h1C00_4000); add_both(32'h1C00_0002);
        repeat (14) cycle();

        // Stall holds off the next grant while an earlier response completes
        add_both(BASE + 32'hC); add_both(BASE + 32'h10);
        cycle();
        stall = 1;
        repeat (5) cycle();
        stall = 0;
        repeat (8) cycle();

        // Reset right after a grant drops the response
        add_both(BASE + 32'h20);
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        repeat (6) cycle();
        add_both(BASE + 32'h24);
        repeat (6) cycle();

        rnd = 1;
        repeat (3000) cycle();
        rnd = 0; rst = 0; stall = 0;
        repeat (8) cycle();
        pv[0] = 0; pv[1] = 0;
        repeat (4) cycle();
        chk("drain", 32'(pend.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
